button_event_gen: RTL and testbench

Conditions a raw push-button into clean, single-cycle user events: 2-flop synchronizer, tick-based debounce, then a press classifier emitting press, short-release, long-press and auto-repeat strobes. It is the producer of the clean button level consumed by the hold-to-reset logic and of the edit/increment strobes used by the clock-setting logic. It is driven by the same 1 ms tick strobe the timebase already generates.

---
 rtl/btn_event_pkg.sv | 15 +
 rtl/btn_debounce.sv | 54 +++++
 rtl/button_event_gen.sv | 112 +++++++++++
 tb/tb_button_event_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared encodings and default timing for the button event generator.
// State values are fixed so other blocks can decode the classifier state.
package btn_event_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPressed  = 2'd1,
    StLongHeld = 2'd2
  } btn_state_e;

  localparam int unsigned DefDebounceMs = 20;
  localparam int unsigned DefLongMs     = 1000;
  localparam int unsigned DefRepeatMs   = 200;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus tick-based debounce of the raw button.
// rise/fall are combinational accept strobes, valid in the cycle btn_level is about to toggle.
module btn_debounce
  import btn_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DefDebounceMs
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_1ms,
  input  logic btn,
  output logic btn_level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_MS - 1);

  logic            s0_q, s1_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;

  always_comb begin
    accept  = tick_1ms && (s1_q != level_q) && (cnt_q == CntLast);
    level_d = level_q ^ accept;
    cnt_d   = cnt_q;
    if ((s1_q == level_q) || accept) begin
      cnt_d = '0;
    end else if (tick_1ms) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s0_q    <= btn;
      s1_q    <= s0_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign rise      = accept && !level_q;
  assign fall      = accept && level_q;

endmodule

// File: rtl/button_event_gen.sv
// Debounced push-button classifier: press, release, short, long and auto-repeat strobes.
// All strobes are registered on the same edge that updates btn_level.
module button_event_gen
  import btn_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DefDebounceMs,
  parameter int unsigned LONG_MS     = DefLongMs,
  parameter int unsigned REPEAT_MS   = DefRepeatMs
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_1ms,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned HoldW = $clog2(LONG_MS + 1);
  localparam int unsigned RepW  = $clog2(REPEAT_MS + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_MS - 1);
  localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_MS - 1);

  logic             rise, fall;
  btn_state_e       state_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic [RepW-1:0]  rep_cnt_q;
  logic             press_q, release_q, short_q, long_q, repeat_q;

  btn_debounce #(
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1ms (tick_1ms),
    .btn      (btn),
    .btn_level(btn_level),
    .rise     (rise),
    .fall     (fall)
  );

  // An accepted fall always takes priority over a coincident long or repeat hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            press_q    <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= StPressed;
          end
        end
        StPressed: begin
          if (fall) begin
            short_q    <= 1'b1;
            release_q  <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= StIdle;
          end else if (tick_1ms) begin
            if (hold_cnt_q == HoldLast) begin
              long_q     <= 1'b1;
              hold_cnt_q <= '0;
              rep_cnt_q  <= '0;
              state_q    <= StLongHeld;
            end else begin
              hold_cnt_q <= hold_cnt_q + HoldW'(1);
            end
          end
        end
        StLongHeld: begin
          if (fall) begin
            release_q <= 1'b1;
            rep_cnt_q <= '0;
            state_q   <= StIdle;
          end else if (tick_1ms) begin
            if (rep_cnt_q == RepLast) begin
              repeat_q  <= 1'b1;
              rep_cnt_q <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + RepW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench: stimulus queues expected strobes tagged with the tick they follow,
// a negedge monitor pops and compares whenever any strobe is seen.
module tb_button_event_gen;
  import btn_event_pkg::*;

  localparam logic [4:0] VPress  = 5'b10000;
  localparam logic [4:0] VRel    = 5'b01000;
  localparam logic [4:0] VShort  = 5'b00100;
  localparam logic [4:0] VLong   = 5'b00010;
  localparam logic [4:0] VRepeat = 5'b00001;

  typedef struct {
    logic [4:0] vec;
    int         tick;
  } exp_t;

  logic clk, rst_n, tick_1ms, btn;
  logic btn_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse;
  logic [4:0] pulses;

  exp_t exp_q[$];
  int   tick_no = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   t;

  button_event_gen #(
    .DEBOUNCE_MS(3),
    .LONG_MS    (10),
    .REPEAT_MS  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1ms     (tick_1ms),
    .btn          (btn),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  assign pulses = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle tick every 5 clocks, driven away from the sampling edge.
  initial begin
    int ph;
    ph = 0;
    tick_1ms = 1'b0;
    forever begin
      @(negedge clk);
      tick_1ms = (ph == 4);
      ph = (ph + 1) % 5;
    end
  end

  always @(posedge clk) if (tick_1ms) tick_no <= tick_no + 1;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (tick %0d)", name, got, want, tick_no);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (tick_1ms !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic expect_at(input logic [4:0] vec, input int tk);
    exp_t e;
    e.vec  = vec;
    e.tick = tk;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && pulses !== 5'b0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse got=%b expected=none (tick %0d)", pulses, tick_no);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_vector", int'(pulses), int'(e.vec));
        check("pulse_tick", tick_no, e.tick);
        if (e.vec[4]) check("level_at_press", int'(btn_level), 1);
        if (e.vec[3]) check("level_at_release", int'(btn_level), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values with an unknown raw button.
    btn   = 1'bx;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_outputs", int'({btn_level, pulses}), 0);
    check("reset_state", int'(dut.state_q), int'(StIdle));
    btn   = 1'b0;
    rst_n = 1'b1;
    wait_ticks(2);

    // Clean short press held 6 ticks.
    t = tick_no;
    btn = 1'b1;
    expect_at(VPress, t + 3);
    wait_ticks(6);
    check("short_level_held", int'(btn_level), 1);
    t = tick_no;
    btn = 1'b0;
    expect_at(VRel | VShort, t + 3);
    wait_ticks(6);

    // 2-tick glitch never accepted.
    btn = 1'b1;
    wait_ticks(2);
    check("glitch_level_mid", int'(btn_level), 0);
    btn = 1'b0;
    wait_ticks(5);
    check("glitch_level_after", int'(btn_level), 0);
    check("glitch_state", int'(dut.state_q), int'(StIdle));

    // Hold 25 ticks: long, three repeats, release only.
    t = tick_no;
    btn = 1'b1;
    expect_at(VPress, t + 3);
    expect_at(VLong, t + 13);
    expect_at(VRepeat, t + 17);
    expect_at(VRepeat, t + 21);
    expect_at(VRepeat, t + 25);
    wait_ticks(25);
    t = tick_no;
    btn = 1'b0;
    expect_at(VRel, t + 3);
    wait_ticks(6);

    // Fall accepted on the 10th hold tick beats the long threshold.
    t = tick_no;
    btn = 1'b1;
    expect_at(VPress, t + 3);
    wait_ticks(10);
    btn = 1'b0;
    expect_at(VRel | VShort, t + 13);
    wait_ticks(6);

    // Reset while long-held aborts silently; held button is re-accepted.
    t = tick_no;
    btn = 1'b1;
    expect_at(VPress, t + 3);
    expect_at(VLong, t + 13);
    wait_ticks(15);
    check("pre_reset_state", int'(dut.state_q), int'(StLongHeld));
    t = tick_no;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midreset_outputs", int'({btn_level, pulses}), 0);
    check("midreset_state", int'(dut.state_q), int'(StIdle));
    rst_n = 1'b1;
    expect_at(VPress, t + 3);
    wait_ticks(5);
    check("post_reset_level", int'(btn_level), 1);
    t = tick_no;
    btn = 1'b0;
    expect_at(VRel | VShort, t + 3);
    wait_ticks(8);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
